ex_mem_stage_buf: RTL and testbench

Parametrised EX→MEM pipeline stage register with valid/ready flow control, flush, and an optional one-entry skid buffer. It sits between the execute stage and the data-cache/memory stage. It holds the write-back control, memory control, ALU result, store data and destination register of one instruction. A MEM-stage stall (dcache miss) back-pressures EX without losing or duplicating an instruction.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/sat_counter.sv | 36 +++
 rtl/ex_mem_stage_buf.sv | 163 ++++++++++++++++
 tb/tb_ex_mem_stage_buf.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the EX->MEM pipeline stage buffer.
//   stage_st_e   : occupancy state of the stage (EMPTY / FULL / SKID)
//   DEF_*        : default widths of the payload fields and stall counter
//   MEM_*_BIT    : bit positions of the read/write strobes in the memory control field
package pipe_pkg;

    localparam int unsigned DEF_WB_W   = 2;
    localparam int unsigned DEF_MEM_W  = 2;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_W  = 5;
    localparam int unsigned DEF_CNT_W  = 16;

    localparam int unsigned MEM_RD_BIT = 0;
    localparam int unsigned MEM_WR_BIT = 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_st_e;

    // Width of one packed payload entry {wb, mem, result, rtdata, writeaddr}.
    function automatic int unsigned payload_w(input int unsigned wb_w,
                                              input int unsigned mem_w,
                                              input int unsigned data_w,
                                              input int unsigned reg_w);
        return wb_w + mem_w + 2 * data_w + reg_w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears the count
//   inc_i  : add one this cycle (ignored once the count is all ones)
//   cnt_o  : current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Hold at the maximum value instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_mem_stage_buf.sv
// ex_mem_stage_buf: EX->MEM pipeline register with valid/ready handshake,
// flush, stall counter and an optional one-entry skid buffer.
//
// Build option: define EX_MEM_SKID_EN to add the skid entry; ready_o then
// comes straight from the state register. Without it ready_o is
// ready_i | ~valid_o and the stage holds at most one instruction.
//
// Ports
//   clk_i, rst_i           : clock, synchronous active-high reset
//   valid_i / ready_o      : upstream (EX) handshake
//   flush_i                : squash every held instruction
//   wb_i, mem_i, result_i,
//   rtdata_i, writeaddr_i  : incoming instruction payload
//   valid_o / ready_i      : downstream (MEM) handshake
//   wb_o, mem_o, result_o,
//   rtdata_o, writeaddr_o  : held instruction (wb/mem forced to 0 on a bubble)
//   stall_cnt_o            : saturating count of cycles with valid_o & ~ready_i
module ex_mem_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned WB_W   = DEF_WB_W,
    parameter int unsigned MEM_W  = DEF_MEM_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    input  logic [WB_W-1:0]   wb_i,
    input  logic [MEM_W-1:0]  mem_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [DATA_W-1:0] rtdata_i,
    input  logic [REG_W-1:0]  writeaddr_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WB_W-1:0]   wb_o,
    output logic [MEM_W-1:0]  mem_o,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] rtdata_o,
    output logic [REG_W-1:0]  writeaddr_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Payload layout, LSB first: writeaddr, rtdata, result, mem, wb.
    localparam int unsigned PL_W    = payload_w(WB_W, MEM_W, DATA_W, REG_W);
    localparam int unsigned CTRL_W  = WB_W + MEM_W;
    localparam int unsigned DPART_W = PL_W - CTRL_W;
    localparam int unsigned WA_LSB  = 0;
    localparam int unsigned RT_LSB  = WA_LSB + REG_W;
    localparam int unsigned RES_LSB = RT_LSB + DATA_W;
    localparam int unsigned MEM_LSB = RES_LSB + DATA_W;
    localparam int unsigned WB_LSB  = MEM_LSB + MEM_W;

    stage_st_e       state_q;
    stage_st_e       state_d;
    logic [PL_W-1:0] main_q;
    logic [PL_W-1:0] main_d;
    logic [PL_W-1:0] in_pl;
    logic            xfer_in;
    logic            xfer_out;

    assign in_pl    = {wb_i, mem_i, result_i, rtdata_i, writeaddr_i};
    assign valid_o  = (state_q != ST_EMPTY);
    assign xfer_in  = valid_i & ready_o;
    assign xfer_out = valid_o & ready_i;

`ifdef EX_MEM_SKID_EN
    logic [PL_W-1:0] skid_q;
    logic [PL_W-1:0] skid_d;

    // Decoded from state only: no path from ready_i to ready_o.
    assign ready_o = (state_q != ST_SKID);
`else
    assign ready_o = ready_i | ~valid_o;
`endif

    // Next-state and payload steering. Flush beats any transfer and keeps
    // data fields, clearing only the wb/mem control so nothing acts later.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef EX_MEM_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = {{CTRL_W{1'b0}}, main_q[DPART_W-1:0]};
`ifdef EX_MEM_SKID_EN
            skid_d  = {{CTRL_W{1'b0}}, skid_q[DPART_W-1:0]};
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        main_d  = in_pl;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (xfer_in && xfer_out) begin
                        main_d = in_pl;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
`ifdef EX_MEM_SKID_EN
                    end else if (xfer_in) begin
                        // MEM stalled: park the new instruction behind main.
                        skid_d  = in_pl;
                        state_d = ST_SKID;
`endif
                    end
                end
`ifdef EX_MEM_SKID_EN
                ST_SKID: begin
                    // Older entry leaves first; skid advances into main.
                    if (xfer_out) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
`ifdef EX_MEM_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef EX_MEM_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

    // A bubble never carries write-back or memory control downstream.
    assign wb_o        = valid_o ? main_q[WB_LSB +: WB_W]   : '0;
    assign mem_o       = valid_o ? main_q[MEM_LSB +: MEM_W] : '0;
    assign result_o    = main_q[RES_LSB +: DATA_W];
    assign rtdata_o    = main_q[RT_LSB +: DATA_W];
    assign writeaddr_o = main_q[WA_LSB +: REG_W];

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (valid_o & ~ready_i),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// tb_ex_mem_stage_buf: randomized self-checking bench for ex_mem_stage_buf.
// The reference is a queue of held instructions (capacity 2 with the skid
// option, 1 without) plus two saturating counters. A second instance with
// CNT_W=2 shares all inputs to exercise counter saturation.
module tb_ex_mem_stage_buf;
    import pipe_pkg::*;

    typedef struct {
        logic [1:0]  wb;
        logic [1:0]  mem;
        logic [31:0] res;
        logic [31:0] rt;
        logic [4:0]  wa;
    } ins_t;

    logic        clk;
    logic        rst_i, valid_i, flush_i, ready_i;
    logic [1:0]  wb_i, mem_i;
    logic [31:0] result_i, rtdata_i;
    logic [4:0]  writeaddr_i;
    logic        ready_o, valid_o;
    logic [1:0]  wb_o, mem_o;
    logic [31:0] result_o, rtdata_o;
    logic [4:0]  writeaddr_o;
    logic [15:0] stall_cnt_o;

    logic        s_ready, s_valid;
    logic [1:0]  s_wb, s_mem;
    logic [31:0] s_result, s_rtdata;
    logic [4:0]  s_wa;
    logic [1:0]  s_cnt;

    ins_t        q[$];
    int unsigned cnt16;
    int unsigned cnt2;
    int          total;
    int          bad;

    ex_mem_stage_buf u_dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .flush_i(flush_i), .wb_i(wb_i), .mem_i(mem_i), .result_i(result_i),
        .rtdata_i(rtdata_i), .writeaddr_i(writeaddr_i), .valid_o(valid_o),
        .ready_i(ready_i), .wb_o(wb_o), .mem_o(mem_o), .result_o(result_o),
        .rtdata_o(rtdata_o), .writeaddr_o(writeaddr_o), .stall_cnt_o(stall_cnt_o)
    );

    ex_mem_stage_buf #(.CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(s_ready),
        .flush_i(flush_i), .wb_i(wb_i), .mem_i(mem_i), .result_i(result_i),
        .rtdata_i(rtdata_i), .writeaddr_i(writeaddr_i), .valid_o(s_valid),
        .ready_i(ready_i), .wb_o(s_wb), .mem_o(s_mem), .result_o(s_result),
        .rtdata_o(s_rtdata), .writeaddr_o(s_wa), .stall_cnt_o(s_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit model_ready(input logic r);
`ifdef EX_MEM_SKID_EN
        return (q.size() < 2);
`else
        return (r == 1'b1) || (q.size() == 0);
`endif
    endfunction

    function automatic ins_t rand_ins();
        ins_t p;
        p.wb  = 2'($urandom);
        p.mem = 2'($urandom);
        p.res = $urandom;
        p.rt  = $urandom;
        p.wa  = 5'($urandom);
        return p;
    endfunction

    // Drive one cycle of inputs, advance the reference at the edge, settle.
    task automatic cycle(input logic v, input logic f, input logic r,
                         input logic rs, input ins_t p);
        bit rdy;
        bit outx;
        valid_i = v; flush_i = f; ready_i = r; rst_i = rs;
        wb_i = p.wb; mem_i = p.mem; result_i = p.res; rtdata_i = p.rt;
        writeaddr_i = p.wa;
        rdy  = model_ready(r);
        outx = (q.size() > 0) && (r == 1'b1);
        @(posedge clk);
        if (rs) begin
            q.delete();
            cnt16 = 0;
            cnt2  = 0;
        end else begin
            if ((q.size() > 0) && (r == 1'b0)) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt2 < 3) cnt2++;
            end
            if (f) begin
                q.delete();
            end else begin
                if (outx) void'(q.pop_front());
                if (v && rdy) q.push_back(p);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        ins_t p;
        p = rand_ins();
        cycle(1'b1, 1'b1, 1'b0, 1'b1, p);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, p);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", valid_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", ready_o); end
        total++;
        if ({wb_o, mem_o, result_o, rtdata_o, writeaddr_o} !== '0) begin
            bad++; $display("FAIL reset_payload got %0h want 0", {wb_o, mem_o, result_o, rtdata_o, writeaddr_o});
        end
        total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", stall_cnt_o); end
        p = '{default: '0};
        cycle(1'b0, 1'b0, 1'b0, 1'b0, p);
    endtask

    task automatic test_single();
        ins_t p;
        p = rand_ins();
        p.res = 32'h0000_0010;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, p);
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got %b want 1", valid_o); end
        total++; if (result_o !== 32'h10) begin bad++; $display("FAIL single_result got %0h want 10", result_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL single_ready got %b want 1", ready_o); end
        total++; if (wb_o !== p.wb || mem_o !== p.mem) begin bad++; $display("FAIL single_ctrl got %0h want %0h", {wb_o, mem_o}, {p.wb, p.mem}); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, p);
        total++; if (valid_o !== 1'b0 || wb_o !== 2'd0 || mem_o !== 2'd0) begin
            bad++; $display("FAIL single_drain got v=%b wb=%0h mem=%0h want 0", valid_o, wb_o, mem_o);
        end
    endtask

    task automatic test_back_to_back();
        ins_t p;
        for (int i = 0; i < 8; i++) begin
            p = rand_ins();
            cycle(1'b1, 1'b0, 1'b1, 1'b0, p);
            total++;
            if (valid_o !== 1'b1 || result_o !== p.res || rtdata_o !== p.rt || writeaddr_o !== p.wa) begin
                bad++; $display("FAIL b2b_%0d got v=%b res=%0h want res=%0h", i, valid_o, result_o, p.res);
            end
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, p);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drain got %b want 0", valid_o); end
    endtask

    task automatic test_skid();
        ins_t a, b, z;
        a = rand_ins(); b = rand_ins(); z = rand_ins();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, z);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, z);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL skid_ready got %b want 0", ready_o); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, z);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, z);
        total++; if (valid_o !== 1'b1 || result_o !== a.res) begin bad++; $display("FAIL skid_first got %0h want %0h", result_o, a.res); end
        total++; if (stall_cnt_o !== 16'd3) begin bad++; $display("FAIL skid_cnt got %0d want 3", stall_cnt_o); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, z);
`ifdef EX_MEM_SKID_EN
        total++; if (valid_o !== 1'b1 || result_o !== b.res || writeaddr_o !== b.wa) begin
            bad++; $display("FAIL skid_second got v=%b res=%0h want %0h", valid_o, result_o, b.res);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, z);
`endif
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL skid_drain got %b want 0", valid_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL skid_ready_back got %b want 1", ready_o); end
    endtask

    task automatic test_flush();
        ins_t a, b, c;
        a = rand_ins(); b = rand_ins(); c = rand_ins();
        a.wb = 2'b11; a.mem = 2'b10;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, a);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, c);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got %b want 0", valid_o); end
        total++; if (wb_o !== 2'd0 || mem_o !== 2'd0) begin bad++; $display("FAIL flush_ctrl got %0h want 0", {wb_o, mem_o}); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL flush_ready got %b want 1", ready_o); end
        total++; if (stall_cnt_o !== 16'd2) begin bad++; $display("FAIL flush_cnt got %0d want 2", stall_cnt_o); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, c);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_drop got %b want 0", valid_o); end
    endtask

    task automatic test_saturation();
        ins_t a;
        a = rand_ins();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, a);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, a);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, a);
        total++; if (s_cnt !== 2'd3) begin bad++; $display("FAIL sat_small got %0d want 3", s_cnt); end
        total++; if (stall_cnt_o !== 16'd6) begin bad++; $display("FAIL sat_wide got %0d want 6", stall_cnt_o); end
    endtask

    task automatic test_reset_mid_stall();
        ins_t a, b;
        a = rand_ins(); b = rand_ins();
        a.res = 32'hdead_beef;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, b);
        total++;
        if ({valid_o, wb_o, mem_o, result_o, rtdata_o, writeaddr_o, stall_cnt_o} !== '0) begin
            bad++; $display("FAIL rst_stall_outputs got v=%b res=%0h cnt=%0d want all 0", valid_o, result_o, stall_cnt_o);
        end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_stall_ready got %b want 1", ready_o); end
    endtask

    task automatic test_random();
        ins_t p;
        logic v, f, r, rs;
        for (int i = 0; i < 600; i++) begin
            p  = rand_ins();
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            f  = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 149) == 0);
            cycle(v, f, r, rs, p);
            total++;
            if (valid_o !== (q.size() > 0) || s_valid !== (q.size() > 0)) begin
                bad++; $display("FAIL rnd_valid_%0d got %b/%b want %b", i, valid_o, s_valid, q.size() > 0);
            end
            total++;
            if (ready_o !== model_ready(r) || s_ready !== model_ready(r)) begin
                bad++; $display("FAIL rnd_ready_%0d got %b/%b want %b", i, ready_o, s_ready, model_ready(r));
            end
            total++;
            if (q.size() > 0) begin
                if ({wb_o, mem_o, result_o, rtdata_o, writeaddr_o} !== {q[0].wb, q[0].mem, q[0].res, q[0].rt, q[0].wa} ||
                    {s_wb, s_mem, s_result, s_rtdata, s_wa} !== {q[0].wb, q[0].mem, q[0].res, q[0].rt, q[0].wa}) begin
                    bad++; $display("FAIL rnd_payload_%0d got %0h want %0h", i,
                        {wb_o, mem_o, result_o, rtdata_o, writeaddr_o}, {q[0].wb, q[0].mem, q[0].res, q[0].rt, q[0].wa});
                end
            end else if ({wb_o, mem_o, s_wb, s_mem} !== 8'd0) begin
                bad++; $display("FAIL rnd_bubble_%0d got %0h want 0", i, {wb_o, mem_o, s_wb, s_mem});
            end
            total++;
            if (stall_cnt_o !== 16'(cnt16) || s_cnt !== 2'(cnt2)) begin
                bad++; $display("FAIL rnd_cnt_%0d got %0d/%0d want %0d/%0d", i, stall_cnt_o, s_cnt, cnt16, cnt2);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        total = 0; bad = 0; cnt16 = 0; cnt2 = 0;
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        wb_i = '0; mem_i = '0; result_i = '0; rtdata_i = '0; writeaddr_i = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_skid();
        test_flush();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
